// File: rtl/seg7_scan_reader_if.sv
// Bus bundle for seg7_scan_reader: display-side segment/strobe lines plus the frame handshake.
// The master modport drives the display lines and consumes frames; the slave is the reader.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    seg_a;
    logic                    seg_b;
    logic                    seg_c;
    logic                    seg_d;
    logic                    seg_e;
    logic                    seg_f;
    logic                    seg_g;
    logic [NUM_DIGITS-1:0]   dig_n;
    logic                    err_clear;
    logic                    out_ready;
    logic                    out_valid;
    logic [4*NUM_DIGITS-1:0] out_bcd;
    logic [NUM_DIGITS-1:0]   out_blank;
    logic [NUM_DIGITS-1:0]   out_invalid;
    logic                    err_invalid;
    logic                    err_overrun;

    modport master (
        output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dig_n, err_clear, out_ready,
        input  out_valid, out_bcd, out_blank, out_invalid, err_invalid, err_overrun
    );

    modport slave (
        input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dig_n, err_clear, out_ready,
        output out_valid, out_bcd, out_blank, out_invalid, err_invalid, err_overrun
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed common-anode 7-segment bus and emits whole frames.
// Define SEG7_SCAN_HEX_EN to also decode the hex glyphs A..F.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    seg7_scan_reader_if.slave bus
);
    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {CAP_WAIT = 1'b0, CAP_HELD = 1'b1} cap_state_e;
    typedef enum logic [0:0] {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

    // Result packing: {blank, invalid, value[3:0]}; segments are active-low, a is the MSB.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'b0000001: r = {2'b00, 4'h0};
            7'b1001111: r = {2'b00, 4'h1};
            7'b0010010: r = {2'b00, 4'h2};
            7'b0000110: r = {2'b00, 4'h3};
            7'b1001100: r = {2'b00, 4'h4};
            7'b0100100: r = {2'b00, 4'h5};
            7'b0100000: r = {2'b00, 4'h6};
            7'b0001111: r = {2'b00, 4'h7};
            7'b0000000: r = {2'b00, 4'h8};
            7'b0000100: r = {2'b00, 4'h9};
`ifdef SEG7_SCAN_HEX_EN
            7'b0001000: r = {2'b00, 4'hA};
            7'b1100000: r = {2'b00, 4'hB};
            7'b0110001: r = {2'b00, 4'hC};
            7'b1000010: r = {2'b00, 4'hD};
            7'b0110000: r = {2'b00, 4'hE};
            7'b0111000: r = {2'b00, 4'hF};
`endif
            7'b1111111: r = {2'b10, 4'h0};
            default:    r = {2'b01, 4'h0};
        endcase
        return r;
    endfunction

    logic [SW-1:0]           sample_q, sample_d, prev_q, prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    cap_state_e              cap_state_q, cap_state_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] dig_val_q, dig_val_d;
    logic [NUM_DIGITS-1:0]   dig_blank_q, dig_blank_d, dig_inv_q, dig_inv_d;
    out_state_e              out_state_q, out_state_d;
    logic [4*NUM_DIGITS-1:0] out_bcd_q, out_bcd_d;
    logic [NUM_DIGITS-1:0]   out_blank_q, out_blank_d, out_inv_q, out_inv_d;
    logic                    err_inv_q, err_inv_d, err_ovr_q, err_ovr_d;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   strobe_s;
    logic [5:0]              dec_s;
    logic                    capture_s, ovr_evt_s;

    // Next-state logic: qualification, debounce, capture, frame assembly and output handshake.
    always_comb begin
        sample_d    = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g, bus.dig_n};
        prev_d      = sample_q;
        cnt_d       = cnt_q;
        cap_state_d = cap_state_q;
        seen_d      = seen_q;
        dig_val_d   = dig_val_q;
        dig_blank_d = dig_blank_q;
        dig_inv_d   = dig_inv_q;
        out_state_d = out_state_q;
        out_bcd_d   = out_bcd_q;
        out_blank_d = out_blank_q;
        out_inv_d   = out_inv_q;
        capture_s   = 1'b0;
        ovr_evt_s   = 1'b0;
        seg_s       = sample_q[SW-1:NUM_DIGITS];
        strobe_s    = sample_q[NUM_DIGITS-1:0];
        dec_s       = decode_seg(seg_s);

        // Any strobe or segment change restarts the debounce; HELD blocks a second capture.
        if (!$onehot(~strobe_s)) begin
            cnt_d       = '0;
            cap_state_d = CAP_WAIT;
        end else if (sample_q != prev_q) begin
            cnt_d       = '0;
            cap_state_d = CAP_WAIT;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = CNT_MAX;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if ((cap_state_q == CAP_WAIT) && (cnt_d == CNT_MAX)) begin
                capture_s   = 1'b1;
                cap_state_d = CAP_HELD;
            end else begin
                cap_state_d = cap_state_q;
            end
        end

        // A completed frame is loaded from the digit registers as they stood before this edge.
        if (&seen_q) begin
            seen_d = '0;
            if ((out_state_q == OUT_EMPTY) || bus.out_ready) begin
                out_bcd_d   = dig_val_q;
                out_blank_d = dig_blank_q;
                out_inv_d   = dig_inv_q;
                out_state_d = OUT_FULL;
            end else begin
                ovr_evt_s = 1'b1;
            end
        end else if ((out_state_q == OUT_FULL) && bus.out_ready) begin
            out_state_d = OUT_EMPTY;
        end else begin
            out_state_d = out_state_q;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture_s && !strobe_s[i]) begin
                dig_val_d[4*i +: 4] = dec_s[3:0];
                dig_blank_d[i]      = dec_s[5];
                dig_inv_d[i]        = dec_s[4];
                seen_d[i]           = 1'b1;
            end else begin
                dig_val_d[4*i +: 4] = dig_val_d[4*i +: 4];
            end
        end

        err_inv_d = (capture_s & dec_s[4]) | (err_inv_q & ~bus.err_clear);
        err_ovr_d = ovr_evt_s | (err_ovr_q & ~bus.err_clear);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_q    <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            cap_state_q <= CAP_WAIT;
            seen_q      <= '0;
            dig_val_q   <= '0;
            dig_blank_q <= '0;
            dig_inv_q   <= '0;
            out_state_q <= OUT_EMPTY;
            out_bcd_q   <= '0;
            out_blank_q <= '0;
            out_inv_q   <= '0;
            err_inv_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            cap_state_q <= cap_state_d;
            seen_q      <= seen_d;
            dig_val_q   <= dig_val_d;
            dig_blank_q <= dig_blank_d;
            dig_inv_q   <= dig_inv_d;
            out_state_q <= out_state_d;
            out_bcd_q   <= out_bcd_d;
            out_blank_q <= out_blank_d;
            out_inv_q   <= out_inv_d;
            err_inv_q   <= err_inv_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign bus.out_valid   = (out_state_q == OUT_FULL);
    assign bus.out_bcd     = out_bcd_q;
    assign bus.out_blank   = out_blank_q;
    assign bus.out_invalid = out_inv_q;
    assign bus.err_invalid = err_inv_q;
    assign bus.err_overrun = err_ovr_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: frame vector table, directed corner sequences, and random
// display traffic checked every cycle against a pin-history reference model.
module tb_seg7_scan_reader;
    localparam int N = 4;
    localparam int S = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] HEXA  = 7'b0001000;
    localparam logic [6:0] PAT [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                         7'b0000000, 7'b0000100};
    localparam logic [6:0] HEXP [0:5] = '{7'b0001000, 7'b1100000, 7'b0110001,
                                          7'b1000010, 7'b0110000, 7'b0111000};

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    seg7_scan_reader_if #(.NUM_DIGITS(N)) bus ();
    seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  p0, p1, p2, p3;
        logic [15:0] bcd;
        logic [3:0]  blank, inv;
        logic        einv;
    } frame_vec_t;
    frame_vec_t vecs [6];

    // reference model state: pin history plus frame/output bookkeeping
    logic [6:0]   m_prev_seg;
    logic [N-1:0] m_prev_dig;
    logic         m_prev_ok;
    int           m_run;
    logic [N-1:0] m_seen, m_dblank, m_dinv, m_blank, m_inv;
    logic [15:0]  m_dval, m_bcd;
    logic         m_valid, m_einv, m_eovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        if (s == BLANK) return {2'b10, 4'h0};
        for (int v = 0; v < 10; v++) if (s == PAT[v]) return {2'b00, 4'(v)};
`ifdef SEG7_SCAN_HEX_EN
        for (int k = 0; k < 6; k++) if (s == HEXP[k]) return {2'b00, 4'(10 + k)};
`endif
        return {2'b01, 4'h0};
    endfunction

    function automatic int zeros(input logic [N-1:0] d);
        int z = 0;
        for (int i = 0; i < N; i++) if (!d[i]) z++;
        return z;
    endfunction

    // Capture happens one edge after a qualified pattern has been on the pins for S cycles.
    task automatic model_step();
        logic [6:0]   cs;
        logic [N-1:0] cd;
        logic [5:0]   dec;
        logic         cap, ovr, inv;
        cs = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g};
        cd = bus.dig_n;
        if (reset) begin
            m_seen = '0; m_dblank = '0; m_dinv = '0; m_blank = '0; m_inv = '0;
            m_dval = '0; m_bcd = '0; m_valid = 1'b0; m_einv = 1'b0; m_eovr = 1'b0;
            m_prev_ok = 1'b0; m_run = 0; m_prev_seg = '0; m_prev_dig = '0;
        end else begin
            cap = m_prev_ok && (m_run == S) && (zeros(m_prev_dig) == 1);
            ovr = 1'b0;
            inv = 1'b0;
            if (m_seen == '1) begin
                if (!m_valid || bus.out_ready) begin
                    m_bcd = m_dval; m_blank = m_dblank; m_inv = m_dinv; m_valid = 1'b1;
                end else ovr = 1'b1;
                m_seen = '0;
            end else if (m_valid && bus.out_ready) m_valid = 1'b0;
            if (cap) begin
                dec = ref_decode(m_prev_seg);
                for (int i = 0; i < N; i++) if (!m_prev_dig[i]) begin
                    m_dval[4*i +: 4] = dec[3:0];
                    m_dblank[i] = dec[5];
                    m_dinv[i] = dec[4];
                    m_seen[i] = 1'b1;
                    inv = dec[4];
                end
            end
            if (bus.err_clear) begin m_einv = 1'b0; m_eovr = 1'b0; end
            if (ovr) m_eovr = 1'b1;
            if (inv) m_einv = 1'b1;
            if (m_prev_ok && cs == m_prev_seg && cd == m_prev_dig) m_run = (m_run > S) ? m_run : m_run + 1;
            else m_run = 1;
            m_prev_seg = cs; m_prev_dig = cd; m_prev_ok = 1'b1;
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return {5'b0, bus.out_valid, bus.out_bcd, bus.out_blank, bus.out_invalid, bus.err_invalid, bus.err_overrun};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model_cycle", dut_pack(), {5'b0, m_valid, m_bcd, m_blank, m_inv, m_einv, m_eovr});
    endtask

    task automatic drive(input logic [6:0] s, input logic [N-1:0] d);
        {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = s;
        bus.dig_n = d;
    endtask

    task automatic scan(input logic [6:0] s, input int d, input int cyc);
        logic [N-1:0] one = 1;
        drive(s, ~(one << d));
        repeat (cyc) tick();
    endtask

    initial begin
        logic [6:0]   rs;
        logic [N-1:0] rd;
        logic [N-1:0] one = 1;
        int           sel;

        vecs[0] = '{PAT[2], PAT[0], PAT[2], PAT[5], 16'h5202, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{PAT[1], PAT[3], PAT[4], PAT[6], 16'h6431, 4'b0000, 4'b0000, 1'b0};
        vecs[2] = '{PAT[7], PAT[8], PAT[9], PAT[0], 16'h0987, 4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{BLANK,  PAT[9], BLANK,  PAT[1], 16'h1090, 4'b0101, 4'b0000, 1'b0};
`ifdef SEG7_SCAN_HEX_EN
        vecs[4] = '{BLANK,  BLANK,  HEXA,   BLANK,  16'h0A00, 4'b1011, 4'b0000, 1'b0};
`else
        vecs[4] = '{BLANK,  BLANK,  HEXA,   BLANK,  16'h0000, 4'b1011, 4'b0100, 1'b1};
`endif
        vecs[5] = '{7'b1111110, PAT[5], PAT[2], PAT[8], 16'h8250, 4'b0000, 4'b0001, 1'b1};

        reset = 1'b1; bus.err_clear = 1'b0; bus.out_ready = 1'b1;
        drive(BLANK, 4'hF);
        repeat (2) tick();
        check("reset_state", dut_pack(), 32'h0);
        reset = 1'b0;

        // frame table: valid must rise exactly one edge after the digit-3 capture
        for (int k = 0; k < 6; k++) begin
            scan(vecs[k].p0, 0, 6);
            scan(vecs[k].p1, 1, 6);
            scan(vecs[k].p2, 2, 6);
            scan(vecs[k].p3, 3, 5);
            check("vec_pre_valid", 32'(bus.out_valid), 32'h0);
            tick();
            check("vec_valid", 32'(bus.out_valid), 32'h1);
            check("vec_bcd", 32'(bus.out_bcd), 32'(vecs[k].bcd));
            check("vec_blank", 32'(bus.out_blank), 32'(vecs[k].blank));
            check("vec_invalid", 32'(bus.out_invalid), 32'(vecs[k].inv));
            check("vec_err_invalid", 32'(bus.err_invalid), 32'(vecs[k].einv));
        end

        // glitching digit 1 never captures until it holds for S cycles
        scan(PAT[4], 0, 6);
        for (int j = 0; j < 4; j++) scan((j % 2 == 1) ? PAT[7] : PAT[3], 1, 3);
        scan(PAT[6], 2, 6);
        scan(PAT[9], 3, 6);
        check("glitch_no_frame", 32'(bus.out_valid), 32'h0);
        scan(PAT[1], 1, 4);
        drive(BLANK, 4'hF);
        repeat (2) tick();
        check("glitch_frame_valid", 32'(bus.out_valid), 32'h1);
        check("glitch_frame_bcd", 32'(bus.out_bcd), 32'h9614);

        // multiple or no strobes low: nothing captured
        drive(PAT[5], 4'b1100);
        repeat (10) tick();
        drive(PAT[5], 4'b1111);
        repeat (10) tick();
        scan(PAT[2], 2, 6);
        scan(PAT[3], 3, 6);
        check("strobe_no_frame", 32'(bus.out_valid), 32'h0);
        scan(PAT[0], 0, 6);
        scan(PAT[8], 1, 6);
        check("strobe_frame_valid", 32'(bus.out_valid), 32'h1);
        check("strobe_frame_bcd", 32'(bus.out_bcd), 32'h3280);

        // overrun, err_clear, and load coinciding with out_ready
        drive(BLANK, 4'hF);
        repeat (2) tick();
        bus.out_ready = 1'b0;
        scan(PAT[1], 0, 6); scan(PAT[2], 1, 6); scan(PAT[3], 2, 6); scan(PAT[4], 3, 6);
        check("ovr_first_valid", 32'(bus.out_valid), 32'h1);
        check("ovr_first_bcd", 32'(bus.out_bcd), 32'h4321);
        check("ovr_first_flag", 32'(bus.err_overrun), 32'h0);
        scan(PAT[5], 0, 6); scan(PAT[6], 1, 6); scan(PAT[7], 2, 6); scan(PAT[8], 3, 6);
        check("ovr_held_bcd", 32'(bus.out_bcd), 32'h4321);
        check("ovr_flag_set", 32'(bus.err_overrun), 32'h1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("ovr_flag_cleared", 32'(bus.err_overrun), 32'h0);
        scan(PAT[9], 0, 6); scan(PAT[0], 1, 6); scan(PAT[1], 2, 6); scan(PAT[2], 3, 5);
        bus.out_ready = 1'b1;
        tick();
        check("ready_load_valid", 32'(bus.out_valid), 32'h1);
        check("ready_load_bcd", 32'(bus.out_bcd), 32'h2109);
        check("ready_load_no_ovr", 32'(bus.err_overrun), 32'h0);

        // reset mid-frame discards partial digits
        scan(PAT[3], 0, 6); scan(PAT[3], 1, 6); scan(PAT[3], 2, 6);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("midreset_state", dut_pack(), 32'h0);
        scan(PAT[9], 3, 6);
        check("midreset_no_early", 32'(bus.out_valid), 32'h0);
        scan(PAT[6], 0, 6); scan(PAT[7], 1, 6); scan(PAT[8], 2, 6);
        check("midreset_valid", 32'(bus.out_valid), 32'h1);
        check("midreset_bcd", 32'(bus.out_bcd), 32'h9876);
        check("midreset_flags", 32'({bus.out_blank, bus.out_invalid}), 32'h0);

        // random display traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 15);
            if (sel < 10) rs = PAT[sel];
            else if (sel == 10) rs = BLANK;
            else if (sel == 11) rs = HEXP[$urandom_range(0, 5)];
            else rs = 7'($urandom);
            if ($urandom_range(0, 9) < 8) rd = ~(one << $urandom_range(0, N - 1));
            else rd = 4'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.err_clear = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            drive(rs, rd);
            repeat ($urandom_range(1, 8)) tick();
        end
        reset = 1'b0;
        bus.err_clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
